compare_search_n: RTL
=====================

// Module: compare_search_n
// PURPOSE
//  Binary-search initiator for the compare_n magnitude comparator.
//  Drives Y_probe into the comparator's Y input and consumes XGY/XEY/XLY to recover the unknown X.
//  X is held on the comparator's X input by the surrounding datapath.
//  Sits beside one comparator instance; result returned through a start/done handshake.
// PARAMETERS
//  WIDTH   8   operand width; must match the attached comparator
//  CW      4   probe_cnt width; must hold WIDTH+1
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      request a search; sampled in IDLE only
//  XGY        in   1      comparator: X > Y_probe (combinational, same cycle)
//  XEY        in   1      comparator: X == Y_probe
//  XLY        in   1      comparator: X < Y_probe
//  Y_probe    out  WIDTH  registered candidate driven to comparator Y
//  busy       out  1      high in SEARCH
//  done       out  1      one-cycle pulse, result/found/probe_cnt valid
//  found      out  1      1: X located; 0: search failed (bounds crossed)
//  result     out  WIDTH  recovered X; held until next start
//  probe_cnt  out  CW     number of flag samples taken in last search
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0: Y_probe, busy, done, found, result, probe_cnt. lo=0, hi=2^WIDTH-1.
//  FSM IDLE -> SEARCH -> DONE -> IDLE.
//  IDLE: on start, set lo=0, hi=2^WIDTH-1, Y_probe=2^(WIDTH-1)-1, probe_cnt=0, then go to SEARCH.
//  SEARCH (busy=1): each edge, sample flags against the current Y_probe and increment probe_cnt.
//   XEY: result<=Y_probe, found<=1, go to DONE.
//   XGY: lo<=Y_probe+1.
//   XLY: hi<=Y_probe-1.
//   Next Y_probe = (lo'+hi')>>1, computed in WIDTH+1 bits; no overflow.
//   Y_probe=2^WIDTH-1 with XGY, or Y_probe=0 with XLY: found<=0, result<=Y_probe, go to DONE (no wrap).
//   lo'>hi' (X changed mid-search): found<=0, result<=Y_probe, go to DONE.
//   Default flag priority XEY > XGY > XLY. No flag set: treated as XLY.
//  DONE: done=1 for exactly one cycle, busy=0, then IDLE.
//  Latency: start at edge N gives first sample at edge N+1. done is high in the cycle after the last sample.
//   Worst case is WIDTH+1 samples.
//  start while busy or in DONE: ignored, never queued.
//  start held high: a new search begins in each IDLE cycle.
//  rst_n low mid-search: immediate abort to reset values; no done pulse.
//  result/found/probe_cnt hold their values through IDLE until the next start.
// CONFIGURATION
//  COMPARE_SEARCH_ERRCHK_EN defined:
//   Adds output err (1 bit, reset 0).
//   In SEARCH, a flag vector that is not one-hot terminates the search: err<=1, found<=0, go to DONE.
//   err clears on the next accepted start.
//  Not defined: no err port; priority decoding above applies.
// TESTING
//  X=127, start pulse -> one probe at 127; done 2 cycles after start, found=1, result=127, probe_cnt=1
//  X=0 -> probes 127,63,31,15,7,3,1,0; found=1, result=0, probe_cnt=8
//  X=255 -> probes 127,191,223,239,247,251,253,254,255; found=1, probe_cnt=9 (worst case), no wrap
//  X=200, start re-pulsed on 3rd SEARCH cycle -> ignored; single done, result=200
//  X=90, rst_n low on 4th SEARCH cycle -> all outputs 0, IDLE, no done; next start gives result=90
//  ERRCHK_EN: force XGY=XLY=1 on first probe -> done next cycle, err=1, found=0, probe_cnt=1

Source files
------------

// File: rtl/compare_search_n_if.sv
// compare_search_n_if: start/done request bus plus comparator probe bus.
// COMPARE_SEARCH_ERRCHK_EN adds the err status line.
interface compare_search_n_if #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
);
  logic             start;
  logic             XGY;
  logic             XEY;
  logic             XLY;
  logic [WIDTH-1:0] Y_probe;
  logic             busy;
  logic             done;
  logic             found;
  logic [WIDTH-1:0] result;
  logic [CW-1:0]    probe_cnt;
`ifdef COMPARE_SEARCH_ERRCHK_EN
  logic             err;

  modport slave (
    input  start, XGY, XEY, XLY,
    output Y_probe, busy, done, found,
    output result, probe_cnt, err
  );

  modport master (
    output start, XGY, XEY, XLY,
    input  Y_probe, busy, done, found,
    input  result, probe_cnt, err
  );
`else
  modport slave (
    input  start, XGY, XEY, XLY,
    output Y_probe, busy, done, found,
    output result, probe_cnt
  );

  modport master (
    output start, XGY, XEY, XLY,
    input  Y_probe, busy, done, found,
    input  result, probe_cnt
  );
`endif
endinterface

// File: rtl/compare_search_n.sv
// compare_search_n: binary-search initiator recovering X from compare_n flags.
// Optional COMPARE_SEARCH_ERRCHK_EN: non-one-hot flags abort with err.
module compare_search_n #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input logic clk,
  input logic rst_n,
  compare_search_n_if.slave bus
);

  localparam logic [WIDTH-1:0] MAXV = '1;
  localparam logic [WIDTH-1:0] MIDV = MAXV >> 1;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] lo, lo_n;
  logic [WIDTH-1:0] hi, hi_n;
  logic [WIDTH-1:0] y, y_n;
  logic [WIDTH-1:0] res, res_n;
  logic             fnd, fnd_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             eq, gt;
  logic             bad;
  logic             fail;

`ifdef COMPARE_SEARCH_ERRCHK_EN
  logic err, err_n;
  assign bad = !$onehot({bus.XGY, bus.XEY, bus.XLY});
  assign bus.err = err;
`else
  assign bad = 1'b0;
`endif

  // XEY wins over XGY; anything else counts as XLY
  assign eq = bus.XEY;
  assign gt = !bus.XEY && bus.XGY;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lo    <= '0;
      hi    <= MAXV;
      y     <= '0;
      res   <= '0;
      fnd   <= 1'b0;
      cnt   <= '0;
`ifdef COMPARE_SEARCH_ERRCHK_EN
      err   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      lo    <= lo_n;
      hi    <= hi_n;
      y     <= y_n;
      res   <= res_n;
      fnd   <= fnd_n;
      cnt   <= cnt_n;
`ifdef COMPARE_SEARCH_ERRCHK_EN
      err   <= err_n;
`endif
    end
  end

  // Next-state and search-step logic
  always_comb begin
    state_n = state;
    lo_n    = lo;
    hi_n    = hi;
    y_n     = y;
    res_n   = res;
    fnd_n   = fnd;
    cnt_n   = cnt;
    fail    = 1'b0;
`ifdef COMPARE_SEARCH_ERRCHK_EN
    err_n   = err;
`endif
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = SEARCH;
          lo_n    = '0;
          hi_n    = MAXV;
          y_n     = MIDV;
          cnt_n   = '0;
`ifdef COMPARE_SEARCH_ERRCHK_EN
          err_n   = 1'b0;
`endif
        end
      end
      SEARCH: begin
        cnt_n = cnt + 1'b1;
        priority case (1'b1)
          bad: begin
            fnd_n   = 1'b0;
            state_n = DONE;
`ifdef COMPARE_SEARCH_ERRCHK_EN
            err_n   = 1'b1;
`endif
          end
          eq: begin
            res_n   = y;
            fnd_n   = 1'b1;
            state_n = DONE;
          end
          gt: begin
            if (y == MAXV) fail = 1'b1;
            else lo_n = y + 1'b1;
          end
          default: begin
            if (y == '0) fail = 1'b1;
            else hi_n = y - 1'b1;
          end
        endcase
        // Crossed bounds mean X moved under us
        if (!bad && !eq && !fail && (lo_n > hi_n))
          fail = 1'b1;
        if (fail) begin
          fnd_n   = 1'b0;
          res_n   = y;
          state_n = DONE;
        end else if (!bad && !eq) begin
          y_n = WIDTH'(({1'b0, lo_n} + {1'b0, hi_n}) >> 1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.Y_probe   = y;
  assign bus.busy      = (state == SEARCH);
  assign bus.done      = (state == DONE);
  assign bus.found     = fnd;
  assign bus.result    = res;
  assign bus.probe_cnt = cnt;

endmodule
